// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Turns a byte stream from a uart_rx into single on-chip bus transactions
//   and returns the response bytes through a uart_tx.
//   Frames are big-endian (MSB byte first):
//     read : 0x52, addr[ADDR_WIDTH/8 bytes]
//     write: 0x57, addr[ADDR_WIDTH/8 bytes], data[DATA_WIDTH/8 bytes]
//   Responses: 0x4B ('K') [+ read data bytes], 0x45 ('E') on bus timeout,
//   0x3F ('?') on an unknown command byte.
//
// Ports
//   clk, n_rst          clock, asynchronous active-low reset
//   i_rx_data/_valid    received byte, one-cycle valid pulse
//   o_tx_data/_valid    byte to transmit; i_tx_busy from the transmitter
//   o_bus_req/_rnw/_addr/_wdata, i_bus_ack, i_bus_rdata   bus master side
//   o_busy              a frame is in progress (state is not IDLE)
//   o_err               one-cycle pulse: bad command, RX gap timeout,
//                       bus timeout, or a byte dropped while busy
//   dbg_state           current FSM state (IDLE=0 ADDR=1 WDATA=2 BUS=3 RESP=4)
//
// Handshakes
//   rx : i_rx_data is taken in any cycle i_rx_data_valid is high; there is no
//        back-pressure, so bytes arriving in BUS or RESP are dropped.
//   tx : a byte is consumed in a cycle with o_tx_data_valid=1 and
//        i_tx_busy=0; valid then stays low for one cycle so the transmitter
//        can raise busy before the next byte is offered.
//   bus: o_bus_req is held with stable rnw/addr/wdata until the cycle
//        i_bus_ack is seen (read data sampled that cycle) or the timeout.
module uart_bus_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RX_TIMEOUT  = 500000,
  parameter int BUS_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_data_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_data_valid,
  input  logic                  i_tx_busy,
  output logic                  o_bus_req,
  output logic                  o_bus_rnw,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [2:0]            dbg_state
);

  localparam int ABYTES = ADDR_WIDTH / 8;
  localparam int DBYTES = DATA_WIDTH / 8;
  localparam int MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
  localparam int BC_W   = $clog2(MAXB) + 1;
  localparam int GAP_W  = $clog2(RX_TIMEOUT) + 1;
  localparam int BTO_W  = $clog2(BUS_TIMEOUT) + 1;
  localparam int RL_W   = $clog2(DBYTES + 1) + 1;
  localparam int RESP_W = 8 + DATA_WIDTH;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BUSTO = 8'h45;
  localparam logic [7:0] RSP_BAD   = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [BTO_W-1:0]      bus_cnt_q, bus_cnt_d;
  logic                  req_q, req_d;
  logic                  tx_valid_q, tx_valid_d;
  // Response bytes are queued MSB first; the top byte is the one on o_tx_data.
  logic [RESP_W-1:0]     resp_q, resp_d;
  logic [RL_W-1:0]       resp_left_q, resp_left_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      bus_cnt_q   <= '0;
      req_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      resp_q      <= '0;
      resp_left_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
      req_q       <= req_d;
      tx_valid_q  <= tx_valid_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    bus_cnt_d   = bus_cnt_q;
    req_d       = req_q;
    tx_valid_d  = tx_valid_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        byte_cnt_d = '0;
        gap_cnt_d  = '0;
        bus_cnt_d  = '0;
        if (i_rx_data_valid) begin
          if (i_rx_data == CMD_READ) begin
            rnw_d   = 1'b1;
            state_d = S_ADDR;
          end else if (i_rx_data == CMD_WRITE) begin
            rnw_d   = 1'b0;
            state_d = S_ADDR;
          end else begin
            resp_d      = {RSP_BAD, {DATA_WIDTH{1'b0}}};
            resp_left_d = RL_W'(1);
            tx_valid_d  = 1'b1;
            err_d       = 1'b1;
            state_d     = S_RESP;
          end
        end
      end

      S_ADDR, S_WDATA: begin
        // A byte in the same cycle the gap limit is hit wins over the timeout.
        if (i_rx_data_valid) begin
          gap_cnt_d = '0;
          if (state_q == S_ADDR) begin
            addr_d = (addr_q << 8) | ADDR_WIDTH'(i_rx_data);
            if (byte_cnt_q == BC_W'(ABYTES - 1)) begin
              byte_cnt_d = '0;
              state_d    = rnw_q ? S_BUS : S_WDATA;
            end else begin
              byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
          end else begin
            wdata_d = (wdata_q << 8) | DATA_WIDTH'(i_rx_data);
            if (byte_cnt_q == BC_W'(DBYTES - 1)) begin
              byte_cnt_d = '0;
              state_d    = S_BUS;
            end else begin
              byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
          end
        end else if (gap_cnt_q == GAP_W'(RX_TIMEOUT - 1)) begin
          gap_cnt_d  = '0;
          byte_cnt_d = '0;
          err_d      = 1'b1;
          state_d    = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      S_BUS: begin
        if (i_rx_data_valid) err_d = 1'b1;
        if (!req_q) begin
          // Entry cycle: raise the request for the following cycle.
          req_d     = 1'b1;
          bus_cnt_d = '0;
        end else if (i_bus_ack) begin
          // Ack on the last allowed cycle still counts as success.
          req_d       = 1'b0;
          resp_d      = rnw_q ? {RSP_OK, i_bus_rdata} : {RSP_OK, {DATA_WIDTH{1'b0}}};
          resp_left_d = rnw_q ? RL_W'(DBYTES + 1) : RL_W'(1);
          tx_valid_d  = 1'b1;
          state_d     = S_RESP;
        end else if (bus_cnt_q == BTO_W'(BUS_TIMEOUT - 1)) begin
          req_d       = 1'b0;
          resp_d      = {RSP_BUSTO, {DATA_WIDTH{1'b0}}};
          resp_left_d = RL_W'(1);
          tx_valid_d  = 1'b1;
          err_d       = 1'b1;
          state_d     = S_RESP;
        end else begin
          bus_cnt_d = bus_cnt_q + BTO_W'(1);
        end
      end

      S_RESP: begin
        if (i_rx_data_valid) err_d = 1'b1;
        if (tx_valid_q) begin
          if (!i_tx_busy) begin
            tx_valid_d  = 1'b0;
            resp_d      = resp_q << 8;
            resp_left_d = resp_left_q - RL_W'(1);
            if (resp_left_q == RL_W'(1)) state_d = S_IDLE;
          end
        end else begin
          // One-cycle gap after a consume is over; offer the next byte.
          tx_valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_tx_data       = resp_q[RESP_W-1 -: 8];
  assign o_tx_data_valid = tx_valid_q;
  assign o_bus_req       = req_q;
  assign o_bus_rnw       = rnw_q;
  assign o_bus_addr      = addr_q;
  assign o_bus_wdata     = wdata_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_err           = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Testbench for uart_bus_bridge: directed frames from the bring-up plan plus
// randomized frames, all checked against a frame-level reference model.
module tb_uart_bus_bridge;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RX_TO  = 100;
  localparam int BUS_TO = 16;

  logic          clk;
  logic          n_rst;
  logic [7:0]    i_rx_data;
  logic          i_rx_data_valid;
  logic [7:0]    o_tx_data;
  logic          o_tx_data_valid;
  logic          i_tx_busy;
  logic          o_bus_req;
  logic          o_bus_rnw;
  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic          i_bus_ack;
  logic [DW-1:0] i_bus_rdata;
  logic          o_busy;
  logic          o_err;
  logic [2:0]    dbg_state;

  uart_bus_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RX_TIMEOUT (RX_TO),
    .BUS_TIMEOUT(BUS_TO)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_rx_data      (i_rx_data),
    .i_rx_data_valid(i_rx_data_valid),
    .o_tx_data      (o_tx_data),
    .o_tx_data_valid(o_tx_data_valid),
    .i_tx_busy      (i_tx_busy),
    .o_bus_req      (o_bus_req),
    .o_bus_rnw      (o_bus_rnw),
    .o_bus_addr     (o_bus_addr),
    .o_bus_wdata    (o_bus_wdata),
    .i_bus_ack      (i_bus_ack),
    .i_bus_rdata    (i_bus_rdata),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters, scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [64:0] exp_bus_q[$];
  int          exp_len_q[$];
  int          exp_err;

  logic [7:0]  tx_got[$];
  logic [64:0] bus_got[$];
  int          req_len_q[$];
  int          err_cnt;
  int          stab_bad;
  int          tx_rd, bus_rd, len_rd, err_mark;

  int          ack_delay;
  int          busy_cyc;
  int          late_req;
  logic [31:0] next_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- transmitter model ----------------
  int   busy_left;
  logic take;
  initial begin
    i_tx_busy = 1'b0;
    busy_left = 0;
    forever begin
      @(negedge clk);
      take = n_rst && o_tx_data_valid && !i_tx_busy;
      if (take) tx_got.push_back(o_tx_data);
      @(posedge clk);
      #1;
      if (take) begin
        i_tx_busy = (busy_cyc > 0);
        busy_left = busy_cyc;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) i_tx_busy = 1'b0;
      end
    end
  end

  // ---------------- bus slave model ----------------
  int          req_cyc;
  int          late_used;
  logic [64:0] first_txn;
  initial begin
    i_bus_ack   = 1'b0;
    i_bus_rdata = '0;
    req_cyc     = 0;
    late_used   = 0;
    stab_bad    = 0;
    first_txn   = '0;
    forever begin
      @(negedge clk);
      if (o_bus_req) begin
        if (req_cyc == 0) begin
          first_txn = {o_bus_rnw, o_bus_addr, o_bus_wdata};
          bus_got.push_back({o_bus_rnw, o_bus_addr, o_bus_rnw ? 32'h0 : o_bus_wdata});
        end else if ({o_bus_rnw, o_bus_addr, o_bus_wdata} != first_txn) begin
          stab_bad++;
        end
        req_cyc++;
      end else if (req_cyc != 0) begin
        req_len_q.push_back(req_cyc);
        req_cyc = 0;
      end
      @(posedge clk);
      #1;
      i_bus_ack   = 1'b0;
      i_bus_rdata = $urandom;
      if (req_cyc != 0 && req_cyc == ack_delay) begin
        i_bus_ack   = 1'b1;
        i_bus_rdata = next_rdata;
      end
      if (late_req > late_used) begin
        i_bus_ack = 1'b1;
        late_used++;
      end
    end
  end

  // ---------------- error pulse monitor ----------------
  initial begin
    err_cnt = 0;
    forever begin
      @(negedge clk);
      if (o_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- reference model ----------------
  // Predicts one frame's bus transaction, req length, response bytes and
  // error pulses from the command, the operands and the ack latency.
  task automatic model_expect(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rdata,
                              input int delay);
    logic rd;
    if (cmd == 8'h52 || cmd == 8'h57) begin
      rd = (cmd == 8'h52);
      exp_bus_q.push_back({rd, addr, rd ? 32'h0 : data});
      if (delay + 1 <= BUS_TO) begin
        exp_len_q.push_back(delay + 1);
        exp_q.push_back(8'h4B);
        if (rd) for (int i = 0; i < 4; i++) exp_q.push_back(rdata[31 - 8*i -: 8]);
      end else begin
        exp_len_q.push_back(BUS_TO);
        exp_q.push_back(8'h45);
        exp_err++;
      end
    end else begin
      exp_q.push_back(8'h3F);
      exp_err++;
    end
  endtask

  task automatic sb_check(input string name);
    int          n_got;
    logic [7:0]  e8;
    logic [64:0] g, e;
    int          gl, el;
    @(posedge clk);
    #1;
    n_got = tx_got.size() - tx_rd;
    check({name, ":tx_count"}, n_got, exp_q.size());
    while (exp_q.size() > 0) begin
      e8 = exp_q.pop_front();
      if (tx_rd < tx_got.size()) begin
        check({name, ":tx_byte"}, tx_got[tx_rd], e8);
        tx_rd++;
      end
    end
    tx_rd = tx_got.size();
    n_got = bus_got.size() - bus_rd;
    check({name, ":bus_count"}, n_got, exp_bus_q.size());
    while (exp_bus_q.size() > 0) begin
      e = exp_bus_q.pop_front();
      if (bus_rd < bus_got.size()) begin
        g = bus_got[bus_rd];
        bus_rd++;
        check({name, ":bus_rnw"}, g[64], e[64]);
        check({name, ":bus_addr"}, g[63:32], e[63:32]);
        check({name, ":bus_wdata"}, g[31:0], e[31:0]);
      end
    end
    bus_rd = bus_got.size();
    while (exp_len_q.size() > 0) begin
      el = exp_len_q.pop_front();
      if (len_rd < req_len_q.size()) begin
        gl = req_len_q[len_rd];
        len_rd++;
        check({name, ":req_len"}, gl, el);
      end
    end
    len_rd = req_len_q.size();
    check({name, ":err_count"}, err_cnt - err_mark, exp_err);
    err_mark = err_cnt;
    exp_err  = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    i_rx_data       = b;
    i_rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int gap_max);
    send_byte(cmd);
    if (cmd == 8'h52 || cmd == 8'h57) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        send_byte(addr[31 - 8*i -: 8]);
      end
      if (cmd == 8'h57) begin
        for (int i = 0; i < 4; i++) begin
          repeat ($urandom_range(0, gap_max)) @(posedge clk);
          send_byte(data[31 - 8*i -: 8]);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) check({name, ":idle_wait"}, o_busy, 1'b0);
  endtask

  task automatic run_frame(input string name, input logic [7:0] cmd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int delay,
                           input int busyc, input int gap_max);
    ack_delay  = delay;
    busy_cyc   = busyc;
    next_rdata = rdata;
    model_expect(cmd, addr, data, rdata, delay);
    send_frame(cmd, addr, data, gap_max);
    wait_idle(name);
    sb_check(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  cmd;
    logic [31:0] a, d, r;
    int          n;

    n_rst           = 1'b0;
    i_rx_data       = '0;
    i_rx_data_valid = 1'b0;
    ack_delay       = 3;
    busy_cyc        = 1;
    late_req        = 0;
    next_rdata      = '0;
    exp_err         = 0;
    err_mark        = 0;
    tx_rd           = 0;
    bus_rd          = 0;
    len_rd          = 0;

    repeat (3) @(negedge clk);
    check("rst:tx_valid", o_tx_data_valid, 1'b0);
    check("rst:tx_data", o_tx_data, 8'h00);
    check("rst:bus_req", o_bus_req, 1'b0);
    check("rst:bus_rnw", o_bus_rnw, 1'b0);
    check("rst:bus_addr", o_bus_addr, 32'h0);
    check("rst:bus_wdata", o_bus_wdata, 32'h0);
    check("rst:busy", o_busy, 1'b0);
    check("rst:err", o_err, 1'b0);
    check("rst:state", dbg_state, 3'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("write", 8'h57, 32'hC000_0000, 32'hDEAD_BEEF, 32'h0, 3, 4, 0);
    run_frame("read", 8'h52, 32'h0000_1004, 32'h0, 32'h1234_5678, 2, 10, 0);
    run_frame("bad_cmd", 8'h41, 32'h0, 32'h0, 32'h0, 2, 3, 0);
    run_frame("read_after_bad", 8'h52, 32'h8000_0040, 32'h0, 32'hCAFE_F00D, 1, 2, 2);

    // Partial frame, then silence: dropped after exactly RX_TO idle cycles.
    send_byte(8'h57);
    send_byte(8'hC0);
    repeat (RX_TO) @(negedge clk);
    check("rxto:busy_before", o_busy, 1'b1);
    @(negedge clk);
    check("rxto:busy_after", o_busy, 1'b0);
    exp_err = 1;
    sb_check("rx_timeout");
    run_frame("read_after_rxto", 8'h52, 32'h0000_0010, 32'h0, 32'h0BAD_CAFE, 2, 3, 1);

    // Next byte lands in the very cycle the gap limit is reached: accepted.
    ack_delay  = 2;
    busy_cyc   = 2;
    next_rdata = 32'h5555_AAAA;
    model_expect(8'h52, 32'h1122_3344, 32'h0, 32'h5555_AAAA, 2);
    send_byte(8'h52);
    repeat (RX_TO - 2) @(posedge clk);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_idle("rxto_edge");
    sb_check("rxto_edge");

    // Bus never acks: 'E' response; bytes during BUS dropped; late ack ignored.
    ack_delay = 1000;
    busy_cyc  = 3;
    model_expect(8'h52, 32'hF000_0000, 32'h0, 32'h0, 1000);
    exp_err = exp_err + 2;
    send_frame(8'h52, 32'hF000_0000, 32'h0, 0);
    n = 0;
    while (!o_bus_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bus_to:req_seen", o_bus_req, 1'b1);
    send_byte(8'h52);
    send_byte(8'h00);
    n = 0;
    while (o_bus_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bus_to:req_dropped", o_bus_req, 1'b0);
    late_req++;
    wait_idle("bus_timeout");
    sb_check("bus_timeout");

    // Ack in the final allowed cycle is a success.
    run_frame("ack_at_limit", 8'h52, 32'h0000_0ABC, 32'h0, 32'h8765_4321, BUS_TO - 1, 2, 0);

    // Reset while the second read data byte is on offer.
    ack_delay  = 2;
    busy_cyc   = 10;
    next_rdata = 32'hA1B2_C3D4;
    send_frame(8'h52, 32'h0000_2000, 32'h0, 0);
    n = 0;
    while (!((tx_got.size() - tx_rd) == 2 && o_tx_data_valid && i_tx_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst:reached", o_tx_data, 8'hB2);
    n_rst = 1'b0;
    #1;
    check("mid_rst:tx_valid", o_tx_data_valid, 1'b0);
    check("mid_rst:bus_req", o_bus_req, 1'b0);
    check("mid_rst:busy", o_busy, 1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (15) @(negedge clk);
    check("mid_rst:state", dbg_state, 3'd0);
    check("mid_rst:tx_count", tx_got.size() - tx_rd, 2);
    check("mid_rst:tx_first", tx_got[tx_rd], 8'h4B);
    check("mid_rst:tx_second", tx_got[tx_rd + 1], 8'hA1);
    tx_rd    = tx_got.size();
    bus_rd   = bus_got.size();
    len_rd   = req_len_q.size();
    err_mark = err_cnt;
    run_frame("after_rst", 8'h57, 32'h0000_3000, 32'h0102_0304, 32'h0, 2, 2, 1);

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(0, 9);
      if (n < 4)      cmd = 8'h52;
      else if (n < 8) cmd = 8'h57;
      else begin
        cmd = 8'($urandom_range(0, 255));
        while (cmd == 8'h52 || cmd == 8'h57) cmd = 8'($urandom_range(0, 255));
      end
      a = $urandom;
      d = $urandom;
      r = $urandom;
      run_frame("random", cmd, a, d, r, $urandom_range(1, 20), $urandom_range(0, 12), 4);
    end

    check("req_stable", stab_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
